// File: rtl/fir_ctrl_axilite.sv
// AXI-Lite control slave for the FIR core: ap_ctrl / data_length registers,
// coefficient window decode onto the tap SRAM, and tap-port arbitration
// between host configuration and engine coefficient reads.
module fir_ctrl_axilite #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic                   eng_tap_EN,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   ap_start,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length
);
  typedef enum logic {AP_IDLE, AP_RUN} ap_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} rd_state_e;
  typedef enum logic [2:0] {RK_NONE, RK_CTRL, RK_LEN, RK_TAP, RK_BUSY} rd_kind_e;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = TAP_BASE + pADDR_WIDTH'(4 * (Tape_Num - 1));

  // Tap decode ignores the byte offset within a word.
  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [pADDR_WIDTH-1:0] a);
    return {a[pADDR_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (word_addr(a) >= TAP_BASE) && (word_addr(a) <= TAP_LAST);
  endfunction

  ap_state_e             ap_q, ap_d;
  rd_state_e             rs_q, rs_d;
  rd_kind_e              rk_q, rk_d;
  logic                  ap_done_q, ap_done_d;
  logic                  ap_start_q, ap_start_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_acc_q;
  logic                  alive_q;   // keeps handshakes off until the first edge after reset
  logic                  wr_acc, ar_acc, run;

  // Writes take priority over reads; a write is never accepted two cycles in a row.
  assign wr_acc      = alive_q & awvalid & wvalid & ~wr_acc_q;
  assign ar_acc      = alive_q & (rs_q == R_IDLE) & arvalid & ~wr_acc;
  assign run         = (ap_q == AP_RUN);
  assign awready     = wr_acc;
  assign wready      = wr_acc;
  assign arready     = ar_acc;
  assign rvalid      = (rs_q == R_VALID);
  assign rdata       = rdata_q;
  assign ap_start    = ap_start_q;
  assign data_length = len_q;

  // Next-state for the ap FSM, register file and read FSM.
  always_comb begin
    ap_d       = ap_q;
    ap_done_d  = ap_done_q;
    ap_start_d = 1'b0;
    len_d      = len_q;
    rs_d       = rs_q;
    rk_d       = rk_q;
    rdata_d    = rdata_q;
    // Clear-on-read first so a coincident engine done overrides it below.
    if (rvalid && rready && rk_q == RK_CTRL) ap_done_d = 1'b0;
    case (ap_q)
      AP_IDLE: begin
        if (wr_acc && awaddr == ADDR_CTRL && wdata[0]) begin
          ap_d       = AP_RUN;
          ap_start_d = 1'b1;
          ap_done_d  = 1'b0;
        end
        if (wr_acc && awaddr == ADDR_LEN) len_d = wdata;
      end
      default: begin
        if (eng_done) begin
          ap_d      = AP_IDLE;
          ap_done_d = 1'b1;
        end
      end
    endcase
    case (rs_q)
      R_IDLE: begin
        if (ar_acc) begin
          rs_d = R_WAIT;
          if (araddr == ADDR_CTRL)     rk_d = RK_CTRL;
          else if (araddr == ADDR_LEN) rk_d = RK_LEN;
          else if (is_tap(araddr))     rk_d = run ? RK_BUSY : RK_TAP;
          else                         rk_d = RK_NONE;
        end
      end
      R_WAIT: begin
        rs_d = R_VALID;
        case (rk_q)
          RK_CTRL: rdata_d = {{(pDATA_WIDTH-3){1'b0}}, ~run, ap_done_q, 1'b0};
          RK_LEN:  rdata_d = len_q;
          RK_TAP:  rdata_d = tap_Do;
          RK_BUSY: rdata_d = '1;
          default: rdata_d = '0;
        endcase
      end
      default: begin
        if (rready) rs_d = R_IDLE;
      end
    endcase
  end

  // Tap port mux: engine owns it while running, otherwise host accesses.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (run) begin
      tap_EN = eng_tap_EN;
      tap_A  = eng_tap_A;
    end else if (wr_acc && is_tap(awaddr)) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = word_addr(awaddr) - TAP_BASE;
      tap_Di = wdata;
    end else if (ar_acc && is_tap(araddr)) begin
      tap_EN = 1'b1;
      tap_A  = word_addr(araddr) - TAP_BASE;
    end
  end

  // State registers.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_q       <= AP_IDLE;
      ap_done_q  <= 1'b0;
      ap_start_q <= 1'b0;
      len_q      <= '0;
      rs_q       <= R_IDLE;
      rk_q       <= RK_NONE;
      rdata_q    <= '0;
      wr_acc_q   <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      ap_q       <= ap_d;
      ap_done_q  <= ap_done_d;
      ap_start_q <= ap_start_d;
      len_q      <= len_d;
      rs_q       <= rs_d;
      rk_q       <= rk_d;
      rdata_q    <= rdata_d;
      wr_acc_q   <= wr_acc;
      alive_q    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_ctrl_axilite.sv
// Directed bench for fir_ctrl_axilite with a behavioural 1-cycle tap SRAM.
module tb_fir_ctrl_axilite;
  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr, tap_A, eng_tap_A;
  logic [31:0] wdata, rdata, tap_Di, tap_Do, data_length;
  logic [3:0]  tap_WE;
  logic        tap_EN, eng_tap_EN, ap_start, eng_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cnt = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] rd;

  fir_ctrl_axilite #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(11)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A),
    .ap_start(ap_start), .eng_done(eng_done), .data_length(data_length)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    cyc <= cyc + 1;
    if (ap_start) start_cnt <= start_cnt + 1;
  end

  // Tap SRAM model: byte writes, registered read data.
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) mem[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
      tap_Do <= mem[tap_A[11:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int n;
    n = 0;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
    @(negedge axis_clk);
    while (!awready && n < 20) begin n++; @(negedge axis_clk); end
    if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, input int hold, input bit pulse_done,
                          output logic [31:0] d);
    int n, t_ar, t_rv;
    n = 0; d = '0;
    arvalid = 1'b1; araddr = a; rready = 1'b0;
    @(negedge axis_clk);
    while (!arready && n < 20) begin n++; @(negedge axis_clk); end
    if (!arready) begin
      chk("ar_timeout", 32'(arready), 32'd1);
      arvalid = 1'b0;
      return;
    end
    t_ar = cyc;
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge axis_clk);
    while (!rvalid && n < 20) begin n++; @(negedge axis_clk); end
    if (!rvalid) begin
      chk("r_timeout", 32'(rvalid), 32'd1);
      return;
    end
    t_rv = cyc;
    chk("rd_latency", 32'(t_rv - t_ar), 32'd2);
    d = rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge axis_clk);
      chk("rd_stable", rdata, d);
      chk("rv_held", 32'(rvalid), 32'd1);
    end
    rready = 1'b1;
    if (pulse_done) eng_done = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;
    eng_done = 1'b0;
  endtask

  logic [31:0] taps [0:10];

  initial begin
    taps = '{32'd0, -32'sd10, -32'sd9, 32'd23, 32'd56, 32'd63, 32'd56, 32'd23, -32'sd9, -32'sd10, 32'd0};
    axis_rst_n = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h000; wdata = 32'h0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    eng_tap_EN = 1'b0; eng_tap_A = '0; eng_done = 1'b0;

    // Reset with a write held on the bus.
    repeat (3) @(negedge axis_clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tap_en", {27'd0, tap_EN, tap_WE}, 32'd0);
    chk("rst_len", data_length, 32'd0);
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    repeat (5) @(posedge axis_clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    axi_read(12'h000, 0, 1'b0, rd);
    chk("ctrl_after_rst", rd, 32'h4);
    chk("no_start_pulse", 32'(start_cnt), 32'd0);

    // Configure while idle and read everything back.
    axi_write(12'h010, 32'd600);
    chk("len_port", data_length, 32'd600);
    for (int i = 0; i < 11; i++) axi_write(12'(32 + 4*i), taps[i]);
    axi_read(12'h010, 1, 1'b0, rd);
    chk("len_rd", rd, 32'd600);
    for (int i = 0; i < 11; i++) begin
      axi_read(12'(32 + 4*i), 3, 1'b0, rd);
      chk($sformatf("tap%0d", i), rd, taps[i]);
    end
    axi_read(12'h04C, 0, 1'b0, rd);
    chk("unmapped_4c", rd, 32'd0);

    // Start: one-cycle pulse, run-state behaviour.
    axi_write(12'h000, 32'd1);
    @(negedge axis_clk);
    chk("start_hi", 32'(ap_start), 32'd1);
    @(negedge axis_clk);
    chk("start_lo", 32'(ap_start), 32'd0);
    @(posedge axis_clk); #1;
    axi_read(12'h000, 0, 1'b0, rd);
    chk("ctrl_run", rd, 32'h0);
    axi_read(12'h024, 0, 1'b0, rd);
    chk("tap_busy", rd, 32'hFFFF_FFFF);
    axi_write(12'h024, 32'd5);
    axi_write(12'h010, 32'd7);
    axi_write(12'h000, 32'd1);
    chk("restart_ignored", 32'(start_cnt), 32'd1);
    eng_tap_EN = 1'b1; eng_tap_A = 12'h014;
    @(negedge axis_clk);
    chk("eng_tap_a", {20'd0, tap_A}, 32'h14);
    chk("eng_tap_en_we", {27'd0, tap_EN, tap_WE}, 32'h10);
    @(posedge axis_clk); #1;
    eng_tap_EN = 1'b0;
    eng_done = 1'b1;
    @(posedge axis_clk); #1;
    eng_done = 1'b0;
    axi_read(12'h000, 0, 1'b0, rd);
    chk("ctrl_done", rd, 32'h6);
    axi_read(12'h000, 0, 1'b0, rd);
    chk("ctrl_cleared", rd, 32'h4);
    axi_read(12'h024, 0, 1'b0, rd);
    chk("tap_kept", rd, 32'hFFFF_FFF6);
    axi_read(12'h010, 0, 1'b0, rd);
    chk("len_kept", rd, 32'd600);

    // Engine taps ignored while idle.
    eng_tap_EN = 1'b1; eng_tap_A = 12'h014;
    @(negedge axis_clk);
    chk("idle_eng_ignored", 32'(tap_EN), 32'd0);
    @(posedge axis_clk); #1;
    eng_tap_EN = 1'b0;

    // Simultaneous write and read: write first, read one cycle later.
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h020; wdata = 32'd0;
    arvalid = 1'b1; araddr = 12'h024;
    @(negedge axis_clk);
    chk("coll_aw", {30'd0, awready, arready}, 32'h2);
    chk("coll_wr_tap", {16'd0, tap_A, tap_WE}, {16'd0, 12'h000, 4'hF});
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge axis_clk);
    chk("coll_ar", {30'd0, awready, arready}, 32'h1);
    chk("coll_rd_tap", {15'd0, tap_EN, tap_A, tap_WE}, {15'd0, 1'b1, 12'h004, 4'h0});
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    @(negedge axis_clk);
    chk("coll_wait", 32'(rvalid), 32'd0);
    @(negedge axis_clk);
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata", rdata, 32'hFFFF_FFF6);
    rready = 1'b1;
    @(posedge axis_clk); #1;
    rready = 1'b0;

    // Engine done coinciding with the clear-read: set wins.
    axi_write(12'h000, 32'd1);
    axi_read(12'h000, 0, 1'b1, rd);
    chk("ctrl_run2", rd, 32'h0);
    axi_read(12'h000, 0, 1'b0, rd);
    chk("done_set_wins", rd, 32'h6);

    // Reset mid-run while a read sits in R_VALID.
    axi_write(12'h000, 32'd1);
    arvalid = 1'b1; araddr = 12'h010;
    @(negedge axis_clk);
    chk("mid_arready", 32'(arready), 32'd1);
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    @(negedge axis_clk);
    @(negedge axis_clk);
    chk("mid_rvalid", 32'(rvalid), 32'd1);
    axis_rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_len", data_length, 32'd0);
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    axi_read(12'h000, 0, 1'b0, rd);
    chk("mid_rst_ctrl", rd, 32'h4);
    axi_read(12'h010, 0, 1'b0, rd);
    chk("mid_rst_len_rd", rd, 32'd0);
    axi_read(12'h034, 0, 1'b0, rd);
    chk("tap5_survives", rd, 32'd63);
    axi_read(12'h044, 0, 1'b0, rd);
    chk("tap9_survives", rd, 32'hFFFF_FFF6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_ctrl_axilite.md
Name: fir_ctrl_axilite

Overview:
AXI-Lite slave and sequencer for the FIR core. It holds the ap_ctrl and data_length registers and decodes the coefficient window into the tap SRAM (bram11). It also arbitrates the single tap-SRAM port between host configuration accesses and the FIR engine's coefficient reads. It sits between the AXI-Lite bus and the FIR datapath/engine.

Parameters:
pADDR_WIDTH, 12, AXI-Lite and SRAM address width
pDATA_WIDTH, 32, data width
Tape_Num, 11, number of coefficients (tap window 0x20 .. 0x20+4*(Tape_Num-1))

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  asynchronous active-low reset
awvalid/awready  in/out  1/1  write-address handshake
awaddr  in  pADDR_WIDTH  write address
wvalid/wready  in/out  1/1  write-data handshake
wdata  in  pDATA_WIDTH  write data
arvalid/arready  in/out  1/1  read-address handshake
araddr  in  pADDR_WIDTH  read address
rvalid/rready  out/in  1/1  read-data handshake
rdata  out  pDATA_WIDTH  read data (registered)
tap_WE  out  4  tap SRAM byte write enables
tap_EN  out  1  tap SRAM enable
tap_Di  out  pDATA_WIDTH  tap SRAM write data
tap_A  out  pADDR_WIDTH  tap SRAM byte address
tap_Do  in  pDATA_WIDTH  tap SRAM read data (1-cycle latency)
eng_tap_EN  in  1  engine coefficient read enable
eng_tap_A  in  pADDR_WIDTH  engine coefficient byte address
ap_start  out  1  one-cycle start pulse to engine
eng_done  in  1  one-cycle pulse: engine accepted last output
data_length  out  pDATA_WIDTH  sample count register

Behaviour:
- Reset (async, any time): ap FSM to IDLE, read FSM to R_IDLE. Outputs: ap_idle=1, ap_done=0, ap_start=0, data_length=0. awready/wready/arready/rvalid=0, rdata=0, tap_EN=0, tap_WE=0. Tap SRAM contents are not cleared.
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start (write-1 triggers, always reads 0), bit1 ap_done, bit2 ap_idle, other bits read 0.
  - 0x10 data_length.
  - Tap window maps to tap_A = addr-0x20.
  - Unmapped: writes are dropped and reads return 0.
- ap FSM: IDLE -> RUN on an accepted write to 0x00 with wdata[0]=1 while IDLE.
  - On that transition: ap_start=1 for exactly one cycle, ap_idle=0, ap_done=0.
  - RUN -> IDLE on eng_done: ap_idle=1, ap_done=1 the following cycle.
  - ap_done clears on a completed read of 0x00 (the rvalid&rready beat). If eng_done and the clear coincide, set wins.
  - A start write in RUN is ignored.
- Write channel: awready=wready=1 for one cycle when awvalid&wvalid are both high, the previous cycle did not accept a write, and the cycle is not an arready cycle. Back-to-back writes therefore take 2 cycles each.
  - In IDLE, data_length and tap writes take effect.
  - Tap write drives the SRAM combinationally in the accept cycle: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata.
  - In RUN, writes to 0x10 and the tap window are acknowledged but discarded.
- Read FSM: R_IDLE -> R_WAIT -> R_VALID -> R_IDLE.
  - R_IDLE: arready=1 for one cycle when arvalid is high and no write is accepted that cycle. A simultaneous write wins; the read is accepted the next eligible cycle.
  - A tap read in IDLE issues tap_EN=1, tap_WE=0, tap_A=araddr-0x20 in the accept cycle.
  - R_WAIT: capture tap_Do or register value into rdata.
  - R_VALID: rvalid=1, rdata held stable until rready; returns to R_IDLE the cycle after the handshake.
  - Read latency: rvalid 2 cycles after arready.
  - A tap read in RUN returns 32'hFFFF_FFFF with no SRAM access.
- Arbitration: in RUN the tap port is owned by the engine: tap_EN=eng_tap_EN, tap_A=eng_tap_A, tap_WE=0. In IDLE the host owns it and eng_tap_EN is ignored.
- Address decode uses awaddr/araddr bits [pADDR_WIDTH-1:0]. Tap addresses must be word-aligned; bits [1:0] are ignored.

Test Plan:
- Reset with awvalid=wvalid=1, addr 0x00 held -> after release, read 0x00 returns 0x04 (idle=1, done=0); ap_start never pulses.
- Write 0x10=600, taps {0,-10,-9,23,56,63,56,23,-9,-10,0} at 0x20..0x48, then read back all -> exact values, each rvalid 2 cycles after arready, rdata stable under rready=0 for 3 cycles.
- Write 0x00=1 -> ap_start high exactly 1 cycle, read 0x00 returns 0x00. Tap read at 0x24 returns 0xFFFFFFFF. Write 0x24=5 and 0x10=7 are dropped; after done, 0x24 still reads -10 and 0x10 still reads 600.
- In RUN, eng_tap_EN=1, eng_tap_A=0x14 -> tap_A=0x14, tap_WE=0. Pulse eng_done -> next read 0x00 returns 0x06, a second read returns 0x04.
- Same-cycle awvalid/wvalid and arvalid in IDLE -> write accepted first, arready 1 cycle later, no tap_EN conflict. eng_done coinciding with the ap_done clear-read -> ap_done remains 1.
- Assert axis_rst_n=0 mid-RUN during R_VALID -> rvalid drops immediately, ap_idle=1, data_length=0; previously written taps still read back.
